lives_manager: RTL and testbench

- Parametrised multi-player successor to the single-player lives counter.
- Holds a saturating lives count per player and applies hits and bonus lives.
- After each hit, gives that player an invulnerability window counted in frame ticks.
- Sequences IDLE/PLAY/PAUSED/OVER for the game top level. Feeds the 7-seg/LED display logic and the obstacle/collision engine.

---
 rtl/lives_manager.sv | 160 ++++++++++++++++
 tb/tb_lives_manager.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lives_manager.sv
// Multi-player lives counter with per-player post-hit grace windows and the
// IDLE/PLAY/PAUSED/OVER game sequencer. All outputs come straight from registers.
module lives_manager #(
    parameter int N_PLAYERS     = 2,
    parameter int WIDTH         = 8,
    parameter int MAX_LIVES     = 99,
    parameter int DEFAULT_LIVES = 3,
    parameter int GRACE_TICKS   = 60
) (
    input  logic                         clkin,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic                         load,
    input  logic [WIDTH-1:0]             load_val,
    input  logic                         start,
    input  logic                         pause,
    input  logic [N_PLAYERS-1:0]         hit,
    input  logic [N_PLAYERS-1:0]         bonus,
    output logic [N_PLAYERS*WIDTH-1:0]   lives,
    output logic [N_PLAYERS-1:0]         alive,
    output logic [N_PLAYERS-1:0]         invuln,
    output logic [1:0]                   state,
    output logic                         game_over,
    output logic                         restart
);

    localparam int GW = $clog2(GRACE_TICKS + 1);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_PLAY   = 2'b01;
    localparam logic [1:0] S_PAUSED = 2'b10;
    localparam logic [1:0] S_OVER   = 2'b11;

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_LIVES);
    localparam logic [WIDTH-1:0] DEF_W   = WIDTH'(DEFAULT_LIVES);
    localparam logic [GW-1:0]    GRACE_W = GW'(GRACE_TICKS);

    logic [WIDTH-1:0]     cnt_q   [N_PLAYERS];
    logic [WIDTH-1:0]     cnt_d   [N_PLAYERS];
    logic [GW-1:0]        grace_q [N_PLAYERS];
    logic [GW-1:0]        grace_d [N_PLAYERS];
    logic [N_PLAYERS-1:0] eff_hit;
    logic [N_PLAYERS-1:0] invuln_d;
    logic [N_PLAYERS-1:0] alive_d;
    logic [1:0]           state_d;
    logic [WIDTH-1:0]     load_clamped;
    logic                 any_alive;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
        assign lives[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state;
        eff_hit      = '0;
        any_alive    = 1'b0;
        load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
        for (int i = 0; i < N_PLAYERS; i++) begin
            cnt_d[i]   = cnt_q[i];
            grace_d[i] = grace_q[i];
        end

        case (state)
            S_IDLE: begin
                if (load) begin
                    for (int i = 0; i < N_PLAYERS; i++) cnt_d[i] = load_clamped;
                end
                if (start) begin
                    // The empty test looks at the value this same edge would load.
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (cnt_d[i] != '0) any_alive = 1'b1;
                    end
                    if (!any_alive) begin
                        for (int i = 0; i < N_PLAYERS; i++) cnt_d[i] = DEF_W;
                    end
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    eff_hit[i] = hit[i] && (cnt_q[i] != '0) && !invuln[i];
                    if (eff_hit[i] && bonus[i]) begin
                        cnt_d[i] = cnt_q[i];
                    end else if (eff_hit[i]) begin
                        cnt_d[i] = cnt_q[i] - WIDTH'(1);
                    end else if (bonus[i] && (cnt_q[i] != '0) && (cnt_q[i] < MAX_W)) begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    end

                    if (eff_hit[i]) begin
                        grace_d[i] = GRACE_W;
                    end else if (tick && (grace_q[i] != '0)) begin
                        grace_d[i] = grace_q[i] - GW'(1);
                    end

                    if (cnt_d[i] == '0) grace_d[i] = '0;
                    if (cnt_d[i] != '0) any_alive = 1'b1;
                end
                if (!any_alive) begin
                    state_d = S_OVER;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end
            end

            S_PAUSED: begin
                if (start) state_d = S_PLAY;
            end

            default: begin
                if (start) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        cnt_d[i]   = DEF_W;
                        grace_d[i] = '0;
                    end
                    state_d = S_PLAY;
                end else if (load) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        cnt_d[i]   = load_clamped;
                        grace_d[i] = '0;
                    end
                    if (load_clamped != '0) state_d = S_IDLE;
                end
            end
        endcase

        for (int i = 0; i < N_PLAYERS; i++) begin
            invuln_d[i] = (grace_d[i] != '0);
            alive_d[i]  = (cnt_d[i] != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            invuln    <= '0;
            alive     <= '0;
            game_over <= 1'b0;
            restart   <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                cnt_q[i]   <= '0;
                grace_q[i] <= '0;
            end
        end else begin
            state     <= state_d;
            invuln    <= invuln_d;
            alive     <= alive_d;
            game_over <= (state_d == S_OVER);
            restart   <= start && ((state == S_PAUSED) || (state == S_OVER));
            for (int i = 0; i < N_PLAYERS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                grace_q[i] <= grace_d[i];
            end
        end
    end

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager with default parameters (2 players, 8-bit,
// max 99, default 3, 60-tick grace window).
module tb_lives_manager;

    logic        clkin = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_val = 8'd0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  hit = 2'b00;
    logic [1:0]  bonus = 2'b00;
    logic [15:0] lives;
    logic [1:0]  alive;
    logic [1:0]  invuln;
    logic [1:0]  state;
    logic        game_over;
    logic        restart;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clkin = ~clkin;

    lives_manager #(
        .N_PLAYERS(2), .WIDTH(8), .MAX_LIVES(99), .DEFAULT_LIVES(3), .GRACE_TICKS(60)
    ) dut (
        .clkin(clkin), .reset_n(reset_n), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .hit(hit), .bonus(bonus), .lives(lives),
        .alive(alive), .invuln(invuln), .state(state), .game_over(game_over), .restart(restart)
    );

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic clear_inputs();
        tick = 1'b0; load = 1'b0; load_val = 8'd0; start = 1'b0;
        pause = 1'b0; hit = 2'b00; bonus = 2'b00;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        step(); step();
        n_checks++;
        if ({state, lives, alive, invuln, game_over, restart} !== 24'd0) begin
            n_fails++;
            $display("FAIL reset_state: state=%b lives=%h alive=%b invuln=%b go=%b rs=%b required all zero",
                     state, lives, alive, invuln, game_over, restart);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_load_clamp();
        load = 1'b1; load_val = 8'hFF; step();
        n_checks++;
        if (lives !== 16'h6363 || alive !== 2'b11 || state !== 2'b00) begin
            n_fails++;
            $display("FAIL load_clamp: lives=%h alive=%b state=%b required 6363 11 00", lives, alive, state);
        end
        load_val = 8'd0; step();
        n_checks++;
        if (lives !== 16'h0000 || alive !== 2'b00) begin
            n_fails++;
            $display("FAIL load_zero: lives=%h alive=%b required 0000 00", lives, alive);
        end
        load_val = 8'hFF; start = 1'b1; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h6363 || state !== 2'b01) begin
            n_fails++;
            $display("FAIL load_start_same_cycle: lives=%h state=%b required 6363 01", lives, state);
        end
        bonus = 2'b11; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h6363) begin
            n_fails++;
            $display("FAIL bonus_saturate: lives=%h required 6363", lives);
        end
    endtask

    task automatic test_grace();
        apply_reset();
        start = 1'b1; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0303 || state !== 2'b01 || restart !== 1'b0) begin
            n_fails++;
            $display("FAIL empty_start: lives=%h state=%b restart=%b required 0303 01 0", lives, state, restart);
        end
        hit = 2'b01; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0302 || invuln !== 2'b01) begin
            n_fails++;
            $display("FAIL first_hit: lives=%h invuln=%b required 0302 01", lives, invuln);
        end
        do_ticks(10);
        hit = 2'b01; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0302 || invuln !== 2'b01) begin
            n_fails++;
            $display("FAIL hit_during_grace: lives=%h invuln=%b required 0302 01", lives, invuln);
        end
        do_ticks(49);
        n_checks++;
        if (invuln !== 2'b01) begin
            n_fails++;
            $display("FAIL grace_tick59: invuln=%b required 01", invuln);
        end
        do_ticks(1);
        n_checks++;
        if (invuln !== 2'b00) begin
            n_fails++;
            $display("FAIL grace_tick60: invuln=%b required 00", invuln);
        end
        hit = 2'b01; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0301 || invuln !== 2'b01) begin
            n_fails++;
            $display("FAIL hit_after_grace: lives=%h invuln=%b required 0301 01", lives, invuln);
        end
    endtask

    task automatic test_simultaneous();
        hit = 2'b10; bonus = 2'b10; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0301 || invuln !== 2'b11) begin
            n_fails++;
            $display("FAIL hit_plus_bonus: lives=%h invuln=%b required 0301 11", lives, invuln);
        end
    endtask

    task automatic test_pause();
        // Both grace counters stand at 60 here; five ticks leave 55 each.
        do_ticks(5);
        pause = 1'b1; bonus = 2'b01; step(); clear_inputs();
        n_checks++;
        if (state !== 2'b10 || lives !== 16'h0302) begin
            n_fails++;
            $display("FAIL pause_entry: state=%b lives=%h required 10 0302", state, lives);
        end
        hit = 2'b11; bonus = 2'b11; tick = 1'b1; load = 1'b1; load_val = 8'd5; pause = 1'b1;
        step(); step(); step(); clear_inputs();
        n_checks++;
        if (state !== 2'b10 || lives !== 16'h0302 || invuln !== 2'b11) begin
            n_fails++;
            $display("FAIL paused_frozen: state=%b lives=%h invuln=%b required 10 0302 11", state, lives, invuln);
        end
        start = 1'b1; step(); clear_inputs();
        n_checks++;
        if (state !== 2'b01 || restart !== 1'b1) begin
            n_fails++;
            $display("FAIL resume: state=%b restart=%b required 01 1", state, restart);
        end
        step();
        n_checks++;
        if (restart !== 1'b0) begin
            n_fails++;
            $display("FAIL resume_pulse_width: restart=%b required 0", restart);
        end
        do_ticks(54);
        n_checks++;
        if (invuln !== 2'b11) begin
            n_fails++;
            $display("FAIL grace_resume_54: invuln=%b required 11", invuln);
        end
        do_ticks(1);
        n_checks++;
        if (invuln !== 2'b00) begin
            n_fails++;
            $display("FAIL grace_resume_55: invuln=%b required 00", invuln);
        end
    endtask

    task automatic test_dead_bonus();
        apply_reset();
        load = 1'b1; load_val = 8'd1; start = 1'b1; step(); clear_inputs();
        hit = 2'b01; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0100 || alive !== 2'b10 || invuln !== 2'b00 || state !== 2'b01) begin
            n_fails++;
            $display("FAIL channel_death: lives=%h alive=%b invuln=%b state=%b required 0100 10 00 01",
                     lives, alive, invuln, state);
        end
        bonus = 2'b11; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0200) begin
            n_fails++;
            $display("FAIL dead_bonus: lives=%h required 0200", lives);
        end
    endtask

    task automatic test_game_over();
        apply_reset();
        load = 1'b1; load_val = 8'd1; start = 1'b1; step(); clear_inputs();
        hit = 2'b11; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0000 || state !== 2'b11 || game_over !== 1'b1 || invuln !== 2'b00) begin
            n_fails++;
            $display("FAIL game_over: lives=%h state=%b go=%b invuln=%b required 0000 11 1 00",
                     lives, state, game_over, invuln);
        end
        load = 1'b1; load_val = 8'd0; step();
        n_checks++;
        if (state !== 2'b11) begin
            n_fails++;
            $display("FAIL over_load_zero: state=%b required 11", state);
        end
        load_val = 8'd7; start = 1'b1; step(); clear_inputs();
        n_checks++;
        if (lives !== 16'h0303 || state !== 2'b01 || restart !== 1'b1 || game_over !== 1'b0) begin
            n_fails++;
            $display("FAIL over_restart: lives=%h state=%b rs=%b go=%b required 0303 01 1 0",
                     lives, state, restart, game_over);
        end
        step();
        n_checks++;
        if (restart !== 1'b0) begin
            n_fails++;
            $display("FAIL restart_pulse_width: restart=%b required 0", restart);
        end
        apply_reset();
        load = 1'b1; load_val = 8'd1; start = 1'b1; step(); clear_inputs();
        hit = 2'b11; step(); clear_inputs();
        load = 1'b1; load_val = 8'd7; step(); clear_inputs();
        n_checks++;
        if (state !== 2'b00 || lives !== 16'h0707) begin
            n_fails++;
            $display("FAIL over_load_idle: state=%b lives=%h required 00 0707", state, lives);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1'b1; step(); clear_inputs();
        hit = 2'b01; step(); clear_inputs();
        n_checks++;
        if (invuln !== 2'b01) begin
            n_fails++;
            $display("FAIL pre_reset_invuln: invuln=%b required 01", invuln);
        end
        hit = 2'b10; bonus = 2'b10; start = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({state, lives, invuln, game_over, restart} !== 22'd0) begin
            n_fails++;
            $display("FAIL async_reset: state=%b lives=%h invuln=%b go=%b rs=%b required all zero",
                     state, lives, invuln, game_over, restart);
        end
        step(); step();
        n_checks++;
        if (restart !== 1'b0 || state !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_hold: restart=%b state=%b required 0 00", restart, state);
        end
        clear_inputs();
        reset_n = 1'b1;
        step();
        n_checks++;
        if (state !== 2'b00 || lives !== 16'h0000) begin
            n_fails++;
            $display("FAIL post_release: state=%b lives=%h required 00 0000", state, lives);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_clamp();
        test_grace();
        test_simultaneous();
        test_pause();
        test_dead_bonus();
        test_game_over();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
